// File: rtl/uart_cmd_wrapper_if.sv
// Bus between the host command link endpoint and the flight command processor.
// Carries the serial pair plus the parallel command/response handshake.
interface uart_cmd_wrapper_if;
  logic        RX;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  modport master (
    output RX, clr_cmd_rdy, resp, send_resp,
    input  TX, cmd, data, cmd_rdy, resp_sent
  );

  modport slave (
    input  RX, clr_cmd_rdy, resp, send_resp,
    output TX, cmd, data, cmd_rdy, resp_sent
  );
endinterface

// File: rtl/uart_cmd_wrapper.sv
// Host command link endpoint: 8N1 receiver, 3-byte frame assembler, 8N1 response transmitter.
// Optional macro FRAME_TIMEOUT_EN discards partial frames after a 20-bit-period idle gap.
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 2604
) (
  input  logic              clk,
  input  logic              rst,
  uart_cmd_wrapper_if.slave bus
);
  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} frm_state_t;
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

  logic rx_s1, rx_s2, rx_d;

  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]       rx_bit, rx_bit_nxt;
  logic [7:0]       rx_shift, rx_shift_nxt;
  logic             start_ok, byte_done, byte_good;

  frm_state_t frm_state, frm_nxt;
  logic       sh_cmd_en, sh_hi_en, frame_done, gap_expired;
  logic [7:0] sh_cmd, sh_hi;
  logic [7:0]  cmd_reg;
  logic [15:0] data_reg;
  logic        rdy_reg;

  tx_state_t        tx_state, tx_nxt;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
  logic [3:0]       tx_bit, tx_bit_nxt;
  logic [8:0]       tx_shift, tx_shift_nxt;
  logic             tx_line, tx_line_nxt, sent_reg, sent_nxt;

  assign bus.cmd       = cmd_reg;
  assign bus.data      = data_reg;
  assign bus.cmd_rdy   = rdy_reg;
  assign bus.TX        = tx_line;
  assign bus.resp_sent = sent_reg;

  // rx_d trails rx_s2 so a start is only taken on a genuine high-to-low transition
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= bus.RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt + CNT_ONE;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    start_ok     = 1'b0;
    byte_done    = 1'b0;
    byte_good    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_nxt = '0;
        if (rx_d && !rx_s2) rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nxt = '0;
          rx_bit_nxt = '0;
          if (rx_s2) begin
            rx_state_nxt = RX_IDLE;
          end else begin
            rx_state_nxt = RX_DATA;
            start_ok     = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
          else                rx_bit_nxt   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = RX_IDLE;
          byte_done    = 1'b1;
          byte_good    = rx_s2;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
    end
  end

  always_ff @(posedge clk) begin
    rx_shift <= rx_shift_nxt;
    if (sh_cmd_en) sh_cmd <= rx_shift;
    if (sh_hi_en)  sh_hi  <= rx_shift;
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int GAP_MAX = 20 * BAUD_DIV;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);
  logic [GAP_W-1:0] gap_cnt;

  // Idle time only accrues while a frame is partially assembled and the line is quiet
  always_ff @(posedge clk) begin
    if (rst || frm_state == WAIT_CMD || rx_state != RX_IDLE) gap_cnt <= '0;
    else if (!gap_expired)                                    gap_cnt <= gap_cnt + GAP_W'(1);
  end

  assign gap_expired = (gap_cnt == GAP_W'(GAP_MAX));
`else
  assign gap_expired = 1'b0;
`endif

  always_comb begin
    frm_nxt    = frm_state;
    sh_cmd_en  = 1'b0;
    sh_hi_en   = 1'b0;
    frame_done = 1'b0;
    if (byte_done && !byte_good) begin
      frm_nxt = WAIT_CMD;
    end else if (byte_done) begin
      case (frm_state)
        WAIT_CMD: begin
          sh_cmd_en = 1'b1;
          frm_nxt   = WAIT_HI;
        end
        WAIT_HI: begin
          sh_hi_en = 1'b1;
          frm_nxt  = WAIT_LO;
        end
        default: begin
          frame_done = 1'b1;
          frm_nxt    = WAIT_CMD;
        end
      endcase
    end else if (gap_expired) begin
      frm_nxt = WAIT_CMD;
    end
  end

  // A newly completed frame takes priority over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      frm_state <= WAIT_CMD;
      cmd_reg   <= '0;
      data_reg  <= '0;
      rdy_reg   <= 1'b0;
    end else begin
      frm_state <= frm_nxt;
      if (frame_done) begin
        cmd_reg  <= sh_cmd;
        data_reg <= {sh_hi, rx_shift};
        rdy_reg  <= 1'b1;
      end else if (bus.clr_cmd_rdy || (start_ok && frm_state == WAIT_CMD)) begin
        rdy_reg  <= 1'b0;
      end
    end
  end

  // tx_shift holds the bits still to go after the one currently on the line
  always_comb begin
    tx_nxt       = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_line_nxt  = tx_line;
    sent_nxt     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_line_nxt = 1'b1;
        if (bus.send_resp) begin
          tx_nxt       = TX_SHIFT;
          tx_shift_nxt = {1'b1, bus.resp};
          tx_line_nxt  = 1'b0;
          tx_cnt_nxt   = '0;
          tx_bit_nxt   = '0;
        end
      end
      default: begin
        tx_cnt_nxt = tx_cnt + CNT_ONE;
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt = '0;
          if (tx_bit == 4'd9) begin
            tx_nxt      = TX_IDLE;
            tx_line_nxt = 1'b1;
            sent_nxt    = 1'b1;
          end else begin
            tx_bit_nxt   = tx_bit + 4'd1;
            tx_line_nxt  = tx_shift[0];
            tx_shift_nxt = {1'b1, tx_shift[8:1]};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_line  <= 1'b1;
      sent_reg <= 1'b0;
    end else begin
      tx_state <= tx_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_line  <= tx_line_nxt;
      sent_reg <= sent_nxt;
    end
  end

  always_ff @(posedge clk) begin
    tx_shift <= tx_shift_nxt;
  end
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Randomized bench for uart_cmd_wrapper: host bytes scored against a byte-level frame model,
// responses decoded off TX at mid-bit. Define FRAME_TIMEOUT_EN to match a timeout build.
module tb_uart_cmd_wrapper;
  localparam int BAUD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_wrapper_if bus();

  uart_cmd_wrapper #(.BAUD_DIV(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: bytes of the frame under assembly and the expected outputs
  int          fm_n     = 0;
  logic [7:0]  fm_b [0:2];
  logic [7:0]  exp_cmd  = 8'h00;
  logic [15:0] exp_data = 16'h0000;
  logic        exp_rdy  = 1'b0;
  bit          line_low = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_rdy"},  32'(bus.cmd_rdy), 32'(exp_rdy));
    check_eq({tag, "_cmd"},  32'(bus.cmd),     32'(exp_cmd));
    check_eq({tag, "_data"}, 32'(bus.data),    32'(exp_data));
  endtask

  task automatic rx_bit(input logic v);
    bus.RX = v;
    repeat (BAUD) @(posedge clk);
    #1;
  endtask

  // A start bit is only visible when the line was high before it
  task automatic host_byte(input logic [7:0] b, input bit stop_ok);
    bit seen;
    seen = !line_low;
    if (seen && fm_n == 0) exp_rdy = 1'b0;
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(stop_ok);
    if (seen) begin
      if (!stop_ok) begin
        fm_n = 0;
      end else begin
        fm_b[fm_n] = b;
        fm_n++;
        if (fm_n == 3) begin
          exp_cmd  = fm_b[0];
          exp_data = {fm_b[1], fm_b[2]};
          exp_rdy  = 1'b1;
          fm_n     = 0;
        end
      end
    end
    line_low = !stop_ok;
    check_outputs("byte");
  endtask

  task automatic host_idle(input int n);
    bus.RX = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    if (n > 0) line_low = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    if (n >= 20 * BAUD) fm_n = 0;
`endif
  endtask

  task automatic clr_pulse();
    bus.clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_cmd_rdy = 1'b0;
    exp_rdy = 1'b0;
    check_outputs("clr");
  endtask

  task automatic tx_xact(input logic [7:0] r, input bit poke);
    logic [9:0] fr;
    fr = {1'b1, r, 1'b0};
    @(posedge clk);
    #1;
    bus.resp      = r;
    bus.send_resp = 1'b1;
    @(posedge clk);
    #1;
    bus.send_resp = 1'b0;
    fork
      begin
        repeat (BAUD / 2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          check_eq($sformatf("tx_bit%0d_of_%02h", i, r), 32'(bus.TX), 32'(fr[i]));
          if (i < 9) repeat (BAUD) @(negedge clk);
        end
        repeat (BAUD / 2 - 1) @(negedge clk);
        check_eq("resp_sent_early", 32'(bus.resp_sent), 32'(0));
        @(negedge clk);
        check_eq("resp_sent", 32'(bus.resp_sent), 32'(1));
        @(negedge clk);
        check_eq("resp_sent_width", 32'(bus.resp_sent), 32'(0));
        check_eq("tx_idle", 32'(bus.TX), 32'(1));
      end
      begin
        if (poke) begin
          repeat (4 * BAUD + 3) @(posedge clk);
          #1;
          bus.resp      = ~r;
          bus.send_resp = 1'b1;
          @(posedge clk);
          #1;
          bus.send_resp = 1'b0;
        end
      end
    join
  endtask

  initial begin
    bus.RX          = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    bus.resp        = 8'h00;
    bus.send_resp   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_tx", 32'(bus.TX), 32'(1));
    check_eq("rst_sent", 32'(bus.resp_sent), 32'(0));
    check_outputs("rst");
    rst = 1'b0;
    host_idle(2 * BAUD);

    host_byte(8'h05, 1'b1);
    host_byte(8'h00, 1'b1);
    host_byte(8'hFF, 1'b1);
    check_eq("t1_cmd_const", 32'(bus.cmd), 32'h05);
    check_eq("t1_data_const", 32'(bus.data), 32'h00FF);
    host_idle(BAUD);
    clr_pulse();

    tx_xact(8'hA5, 1'b1);

    // Second byte framing error; the following 0x80 rides on the low stop and is never seen
    host_idle(BAUD);
    host_byte(8'h03, 1'b1);
    host_byte(8'hFF, 1'b0);
    host_byte(8'h80, 1'b1);
    check_eq("err_no_rdy", 32'(bus.cmd_rdy), 32'(0));
    host_byte(8'h02, 1'b1);
    host_byte(8'h01, 1'b1);
    host_byte(8'h00, 1'b1);
    check_eq("err_cmd_const", 32'(bus.cmd), 32'h02);
    check_eq("err_data_const", 32'(bus.data), 32'h0100);

    // Short low glitch is a false start and must not clear cmd_rdy
    host_idle(BAUD);
    bus.RX = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    host_idle(2 * BAUD);
    check_outputs("glitch");

    host_byte(8'h01, 1'b1);
    host_byte(8'h02, 1'b1);
    host_byte(8'h03, 1'b1);
    host_byte(8'h04, 1'b1);
    host_byte(8'h00, 1'b1);
    host_byte(8'h80, 1'b1);
    check_eq("b2b_cmd_const", 32'(bus.cmd), 32'h04);
    check_eq("b2b_data_const", 32'(bus.data), 32'h0080);

    // Reset after 1.5 bytes while a response is mid-flight
    host_idle(BAUD);
    fork
      begin
        host_byte(8'h09, 1'b1);
        rx_bit(1'b0);
        rx_bit(1'b1);
        rx_bit(1'b1);
        rx_bit(1'b1);
      end
      begin
        repeat (13 * BAUD) @(posedge clk);
        #1;
        bus.resp      = 8'h00;
        bus.send_resp = 1'b1;
        @(posedge clk);
        #1;
        bus.send_resp = 1'b0;
      end
    join
    check_eq("tx_busy_pre_rst", 32'(bus.TX), 32'(0));
    rst    = 1'b1;
    bus.RX = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_mid_tx", 32'(bus.TX), 32'(1));
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    fm_n     = 0;
    exp_cmd  = 8'h00;
    exp_data = 16'h0000;
    exp_rdy  = 1'b0;
    line_low = 1'b0;
    check_outputs("rst_mid");
    check_eq("rst_mid_sent", 32'(bus.resp_sent), 32'(0));
    host_idle(BAUD);
    host_byte(8'h0A, 1'b1);
    host_byte(8'h12, 1'b1);
    host_byte(8'h34, 1'b1);

    host_idle(BAUD);
    clr_pulse();
    host_byte(8'h06, 1'b1);
    host_idle(25 * BAUD);
    host_byte(8'h07, 1'b1);
    host_byte(8'h00, 1'b1);
    host_byte(8'h00, 1'b1);
`ifdef FRAME_TIMEOUT_EN
    check_eq("gap_cmd_const", 32'(bus.cmd), 32'h07);
    check_eq("gap_data_const", 32'(bus.data), 32'h0000);
`else
    check_eq("gap_cmd_const", 32'(bus.cmd), 32'h06);
    check_eq("gap_data_const", 32'(bus.data), 32'h0700);
`endif
    host_idle(BAUD);

    fork
      begin
        for (int k = 0; k < 45; k++) begin
          logic [7:0] b;
          bit ok;
          b  = 8'($urandom);
          ok = ($urandom_range(0, 7) != 0);
          host_byte(b, ok);
          if (!ok)                            host_idle(BAUD + $urandom_range(0, BAUD));
          else if ($urandom_range(0, 1) == 1) host_idle($urandom_range(1, 2 * BAUD));
          if (!line_low && $urandom_range(0, 3) == 0) clr_pulse();
        end
      end
      begin
        for (int k = 0; k < 5; k++) begin
          repeat ($urandom_range(0, 200)) @(posedge clk);
          tx_xact(8'($urandom), bit'($urandom_range(0, 1)));
        end
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_cmd_wrapper.md
# uart_cmd_wrapper

Copter-side end of the host command link. Receives 3-byte command frames (cmd, data high, data low) serially on RX from the remote host and presents them as a parallel cmd/data word with a cmd_rdy flag to the flight command processor. Serializes the processor's one-byte response (ack/status) back to the host on TX. Contains its own 8N1 UART receiver and transmitter plus the frame-assembly state machine.

## Interface
- BAUD_DIV, 2604, clocks per bit period (50 MHz / 19200 baud); must be ≥ 16
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- RX  in  1  serial input from host, asynchronous, idle high
- TX  out  1  serial output to host, idle high
- cmd  out  8  opcode byte of the last complete frame
- data  out  16  payload of the last complete frame, {byte2, byte3}
- cmd_rdy  out  1  set when a complete frame is latched
- clr_cmd_rdy  in  1  single-cycle pulse from consumer, clears cmd_rdy
- resp  in  8  response byte to transmit
- send_resp  in  1  single-cycle pulse, starts transmission of resp
- resp_sent  out  1  single-cycle pulse when the response stop bit completes

## Operation
- RX passes through a 2-flop synchronizer; both flops reset to 1.
- Receiver: falling edge on synchronized RX in RX_IDLE starts a byte. After BAUD_DIV/2 clocks the start bit is re-sampled; if high → false start, back to RX_IDLE. Then 8 data bits (LSB first) and stop bit sampled every BAUD_DIV clocks at mid-bit.
- Stop bit sampled 0 = framing error: byte discarded, frame FSM returns to WAIT_CMD.
- Frame FSM states: WAIT_CMD → WAIT_HI → WAIT_LO → WAIT_CMD, advancing on each good byte. Bytes held in shadow registers; cmd and data outputs update atomically only on the third good byte.
- cmd_rdy set the cycle after the third byte's stop-bit sample; cleared by clr_cmd_rdy or by the start of the next frame's first byte (start bit accepted in WAIT_CMD). cmd/data hold their values until the next complete frame.
- Transmitter states TX_IDLE, TX_SHIFT: send_resp in TX_IDLE latches {1'b1, resp, 1'b0} and shifts LSB first, one bit per BAUD_DIV clocks, 10 bits total. send_resp while in TX_SHIFT is ignored.
- Receiver and transmitter operate independently (full duplex).

## Timing
- Reset values: TX=1, cmd=8'h00, data=16'h0000, cmd_rdy=0, resp_sent=0, all FSMs idle (RX_IDLE, WAIT_CMD, TX_IDLE), counters 0.
- Reset mid-byte or mid-frame: partial data discarded; TX driven high on the first edge with rst asserted.
- TX start bit appears on the clock edge after send_resp; each bit lasts exactly BAUD_DIV clocks; resp_sent pulses the cycle after the stop-bit period ends (10·BAUD_DIV+1 clocks after send_resp); TX_IDLE re-entered the same cycle.
- cmd_rdy latency: 1 clock after third stop-bit mid-sample.
- clr_cmd_rdy in the same cycle cmd_rdy is set: set wins.
- Back-to-back frames with zero inter-byte gap supported: receiver accepts a new start bit from the stop-bit mid-sample onward.

## Configuration
- FRAME_TIMEOUT_EN defined: a gap counter starts after each good byte in WAIT_HI/WAIT_LO; if no start bit arrives within 20·BAUD_DIV clocks the shadow bytes are discarded and the frame FSM returns to WAIT_CMD (cmd_rdy and outputs unaffected).
- Not defined: no gap counter; frame FSM waits indefinitely for the remaining bytes.

## Test plan
- Host sends 8'h05, 8'h00, 8'hFF → cmd_rdy rises once, cmd=8'h05, data=16'h00FF; clr_cmd_rdy pulse → cmd_rdy=0, cmd/data unchanged.
- send_resp with resp=8'hA5 → TX shows 0,1,0,1,0,0,1,0,1,1 at BAUD_DIV spacing; resp_sent pulses at 10·BAUD_DIV+1 clocks; second send_resp mid-byte ignored.
- Frame 8'h03, 8'hFF, 8'h80 with second byte stop bit forced 0 → no cmd_rdy; a following clean frame 8'h02,8'h01,8'h00 → cmd=8'h02, data=16'h0100.
- Two frames back to back without clearing → cmd_rdy drops at second frame's first start bit, rises again with cmd=8'h04, data=16'h0080.
- rst asserted after 1.5 bytes of a frame → all outputs at reset values; next full frame decodes correctly.
- With FRAME_TIMEOUT_EN: send 8'h06, idle 25·BAUD_DIV clocks, then 8'h07,8'h00,8'h00 → cmd=8'h07, data=16'h0000; without macro the same stimulus yields cmd=8'h06, data=16'h0700.
